data_expander: RTL and testbench

Widens 8-bit Q4.4 two's-complement samples to 16-bit Q8.8 and emits each result as two bytes, MSB first, over an 8-bit byte stream with valid/ready handshake. It sits on the path from the NPU's 8-bit result side toward the 16-bit byte-serial (PISO/SIPO) interface. It is the widening counterpart of the team's 16→8 narrowing converter. A small input FIFO decouples the producer from the byte-serial consumer.

---
 rtl/data_expander.sv | 130 +++++++++++++
 tb/tb_data_expander.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_expander.sv
// data_expander: widens Q4.4 samples to Q8.8 and streams each word as two
// bytes, MSB first, behind a small input FIFO with valid/ready on both sides.
module data_expander #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic [7:0]                   in_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [7:0]                   out_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_MSB = 2'd1,
    SEND_LSB = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Serializer state
  state_e        state_q, state_d;
  logic [15:0]   word_q, word_d;
  logic [7:0]    out_q, out_d;

  logic          push, pop, accept, fifo_empty;
  logic [7:0]    head;
  logic [15:0]   expanded;

  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (state_q != IDLE);
  assign out_o       = out_q;
  assign count_o     = count_q;

  assign push       = enable_i & in_valid_i & in_ready_o;
  assign accept     = enable_i & out_valid_o & out_ready_i;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  // Q4.4 -> Q8.8 is exact: sign-extend the integer part, zero-fill the fraction.
  assign expanded   = {{4{head[7]}}, head, 4'b0000};

  // Serializer next state: load on pop, step MSB -> LSB on each accepted byte.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    word_d  = word_q;
    out_d   = out_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && !fifo_empty) begin
          pop     = 1'b1;
          word_d  = expanded;
          out_d   = expanded[15:8];
          state_d = SEND_MSB;
        end
      end
      SEND_MSB: begin
        out_d = word_q[15:8];
        if (accept) begin
          out_d   = word_q[7:0];
          state_d = SEND_LSB;
        end
      end
      SEND_LSB: begin
        if (accept) begin
          if (!fifo_empty) begin
            // Back-to-back reload keeps the byte stream free of idle bubbles.
            pop     = 1'b1;
            word_d  = expanded;
            out_d   = expanded[15:8];
            state_d = SEND_MSB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer registers; reset drops out_valid without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      out_q   <= out_d;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q alone decides which entries are valid.
    if (push) mem_q[wr_ptr_q] <= in_i;
  end

endmodule

// File: tb/tb_data_expander.sv
// Testbench for data_expander: vector table, hand-written corner sequences,
// and a randomized run scored against a queue-based reference model.
module tb_data_expander;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [7:0]    in_d;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_b;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  data_expander #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .in_i        (in_d),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_o       (out_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .count_o     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: Q4.4 value times 16 is the Q8.8 word.
  function automatic logic [15:0] expand(input logic [7:0] s);
    int v;
    v = $signed(s);
    return 16'(v * 16);
  endfunction

  // Reference narrowing: take [11:4], round on bit 3, saturate to 8 bits.
  function automatic logic [7:0] narrow(input logic [15:0] w);
    int v, r;
    v = $signed(w);
    r = (v + 8) >>> 4;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  // Stream monitor: samples handshakes mid-cycle, scores words against pushed samples.
  bit         mon_on = 1'b0;
  logic [7:0] exp_q[$];
  int         n_push = 0;
  int         n_words = 0;
  bit         have_msb = 1'b0;
  logic [7:0] msb_b;

  always @(negedge clk) begin
    if (mon_on && rst_n === 1'b1) begin
      if (enable && in_valid && in_ready) begin
        exp_q.push_back(in_d);
        n_push++;
      end
      if (enable && out_valid && out_ready) begin
        if (!have_msb) begin
          msb_b    = out_b;
          have_msb = 1'b1;
        end else begin
          logic [15:0] w;
          logic [7:0]  s;
          w        = {msb_b, out_b};
          have_msb = 1'b0;
          n_words++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(w), 32'hFFFF_FFFF);
          end else begin
            s = exp_q.pop_front();
            check("stream_word", 32'(w), 32'(expand(s)));
            check("round_trip", 32'(narrow(w)), 32'(s));
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0] din;
    logic [7:0] msb;
    logic [7:0] lsb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] samp[6];
    logic [15:0] w;
    int base, cyc;

    vecs[0] = '{8'h7F, 8'h07, 8'hF0};
    vecs[1] = '{8'h80, 8'hF8, 8'h00};
    vecs[2] = '{8'h01, 8'h00, 8'h10};
    vecs[3] = '{8'hFF, 8'hFF, 8'hF0};
    vecs[4] = '{8'h00, 8'h00, 8'h00};
    vecs[5] = '{8'h35, 8'h03, 8'h50};
    vecs[6] = '{8'h10, 8'h01, 8'h00};
    vecs[7] = '{8'h5A, 8'h05, 8'hA0};
    vecs[8] = '{8'hA5, 8'hFA, 8'h50};

    rst_n = 1'b0; enable = 1'b1; in_d = '0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out", 32'(out_b), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    #4 rst_n = 1'b1;
    tick();

    // Single-word vectors: push, MSB one edge after count=1, LSB, then idle holding LSB.
    for (int i = 0; i < 9; i++) begin
      in_d = vecs[i].din; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("vec_count1", 32'(count), 32'h1);
      check("vec_idle", 32'(out_valid), 32'h0);
      tick();
      check("vec_msb_valid", 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_msb", i), 32'(out_b), 32'(vecs[i].msb));
      tick();
      check("vec_lsb_valid", 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_lsb", i), 32'(out_b), 32'(vecs[i].lsb));
      tick();
      check("vec_after_valid", 32'(out_valid), 32'h0);
      check("vec_out_hold", 32'(out_b), 32'(vecs[i].lsb));
    end

    // Back-to-back 01, FF, 00: six continuous bytes, no bubble.
    samp[0] = 8'h01; samp[1] = 8'hFF; samp[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      in_d = samp[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    begin
      logic [7:0] exp_bytes[6];
      exp_bytes = '{8'h00, 8'h10, 8'hFF, 8'hF0, 8'h00, 8'h00};
      // Edges 2 and 3 already passed: first MSB after edge 2, LSB after edge 3.
      // Re-run from a clean idle instead: check the remaining stream below.
      check("b2b_valid_e3", 32'(out_valid), 32'h1);
      check("b2b_byte1", 32'(out_b), 32'(exp_bytes[1]));
      for (int j = 2; j < 6; j++) begin
        tick();
        check("b2b_valid", 32'(out_valid), 32'h1);
        check($sformatf("b2b_byte%0d", j), 32'(out_b), 32'(exp_bytes[j]));
      end
      tick();
      check("b2b_idle", 32'(out_valid), 32'h0);
    end

    // Fill with out_ready low: DEPTH in FIFO plus one in the serializer.
    samp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_d = samp[i]; in_valid = 1'b1;
      tick();
    end
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_msb_held", 32'(out_b), 32'(expand(samp[0]) >> 8));
    check("full_valid", 32'(out_valid), 32'h1);
    in_d = samp[5];
    tick();
    in_valid = 1'b0;
    check("full_reject", 32'(count), 32'(DEPTH));
    // Enable low freezes everything even with both handshakes asserted.
    enable = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    check("en_hold_out", 32'(out_b), 32'(expand(samp[0]) >> 8));
    check("en_hold_valid", 32'(out_valid), 32'h1);
    check("en_hold_count", 32'(count), 32'(DEPTH));
    check("en_in_ready", 32'(in_ready), 32'h0);
    enable = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w = expand(samp[i/2]);
      check("drain_valid", 32'(out_valid), 32'h1);
      check($sformatf("drain_byte%0d", i), 32'(out_b), 32'((i % 2 == 0) ? w[15:8] : w[7:0]));
      tick();
    end
    check("drain_idle", 32'(out_valid), 32'h0);
    check("drain_in_ready", 32'(in_ready), 32'h1);

    // Asynchronous reset between MSB and LSB with two words queued.
    out_ready = 1'b0;
    samp[0] = 8'h35; samp[1] = 8'h11; samp[2] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      in_d = samp[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("mid_msb", 32'(out_b), 32'h03);
    check("mid_count", 32'(count), 32'h2);
    out_ready = 1'b1;
    tick();
    check("mid_lsb", 32'(out_b), 32'h50);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_count", 32'(count), 32'h0);
    check("arst_out", 32'(out_b), 32'h00);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    #2 rst_n = 1'b1;
    in_d = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("cold_count", 32'(count), 32'h1);
    tick();
    check("cold_msb", 32'(out_b), 32'h01);
    tick();
    check("cold_lsb", 32'(out_b), 32'h00);
    tick();
    check("cold_idle", 32'(out_valid), 32'h0);
    tick();
    check("cold_no_stale", 32'(out_valid), 32'h0);

    // Push and pop together at count=2 across pointer wrap (3*DEPTH words).
    mon_on = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_d = 8'(8'hC0 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pp_preload", 32'(count), 32'h2);
    out_ready = 1'b1;
    tick();
    for (int i = 3; i < 3 * DEPTH; i++) begin
      in_d = 8'(8'hC0 + i * 7); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("pp_count", 32'(count), 32'h2);
      tick();
    end
    cyc = 0;
    while ((out_valid || exp_q.size() != 0) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("pp_drain_timeout", 32'(cyc < 200), 32'h1);
    check("pp_words", 32'(n_words), 32'(3 * DEPTH));

    // Random: enable 1 in 3 cycles, random out_ready, 200 samples.
    base = n_push;
    n_words = 0;
    cyc = 0;
    while ((n_push - base < 200 || out_valid || exp_q.size() != 0) && cyc < 20000) begin
      enable    = (cyc % 3 == 0);
      in_valid  = (n_push - base < 200) && ($urandom_range(0, 1) == 1);
      in_d      = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    enable = 1'b1; in_valid = 1'b0;
    check("rand_timeout", 32'(cyc < 20000), 32'h1);
    check("rand_pushed", 32'(n_push - base), 32'd200);
    check("rand_words", 32'(n_words), 32'd200);
    check("rand_leftover", 32'(exp_q.size()), 32'h0);
    check("rand_half_word", 32'(have_msb), 32'h0);
    mon_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
